// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// word geometry and the load-length acceptance rule.
package loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE,
        ERR
    } state_e;

    // A load is accepted only if it asks for at least one word and fits the memory.
    function automatic logic len_valid(input logic [15:0] len, input int depth);
        return (len != 16'd0) && ({16'd0, len} <= 32'(depth));
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Loader bus: start/length request, byte stream in, instruction-memory write
// port and core-control status out. The loader is the slave side.
interface prog_loader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start_i;
    logic [15:0]           len_i;
    logic                  byte_valid_i;
    logic [7:0]            byte_data_i;
    logic                  byte_ready_o;
    logic                  mem_we_o;
    logic [DATA_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  cpu_rst_o;
    logic                  done_o;
    logic                  err_o;

    modport slave (
        input  start_i, len_i, byte_valid_i, byte_data_i,
        output byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
               cpu_rst_o, done_o, err_o
    );

    modport master (
        output start_i, len_i, byte_valid_i, byte_data_i,
        input  byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
               cpu_rst_o, done_o, err_o
    );
endinterface

// File: rtl/byte_packer.sv
// Little-endian word assembly: each accepted byte lands in the lane selected
// by its index; the register holds its contents across input stalls.
module byte_packer
    import loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr_i,
    input  logic                        we_i,
    input  logic [BYTE_IDX_W-1:0]       idx_i,
    input  logic [7:0]                  byte_i,
    output logic [8*BYTES_PER_WORD-1:0] word_o
);

    logic [8*BYTES_PER_WORD-1:0] word_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
        end else if (clr_i) begin
            word_q <= '0;
        end else if (we_i) begin
            word_q[{idx_i, 3'b000} +: 8] <= byte_i;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: streams bytes into words, writes them to
// instruction memory from BASE_ADDR upward and releases the core when done.
module prog_loader
    import loader_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR   = '0
) (
    input logic           clk,
    input logic           rst,
    prog_loader_if.slave  bus
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    state_e                  state_q;
    logic [15:0]             len_q;
    logic [15:0]             word_cnt_q;
    logic [BYTE_IDX_W-1:0]   byte_idx_q;
    logic                    byte_ready_q;
    logic                    mem_we_q;
    logic [DATA_WIDTH-1:0]   mem_addr_q;
    logic                    cpu_rst_q;
    logic                    done_q;
    logic                    err_q;

    logic                    byte_fire;
    logic                    start_ok;
    logic [DATA_WIDTH-1:0]   mem_addr_d;
    logic [8*BYTES_PER_WORD-1:0] packed_word;

    // byte_ready_q is high exactly in RECV, so it also gates bytes outside RECV.
    assign byte_fire  = bus.byte_valid_i && byte_ready_q;
    assign start_ok   = bus.start_i && (state_q inside {IDLE, DONE, ERR})
                        && len_valid(bus.len_i, DEPTH_WORDS);
    assign mem_addr_d = BASE_ADDR
                        + DATA_WIDTH'(word_cnt_q) * DATA_WIDTH'(BYTES_PER_WORD);

    byte_packer u_packer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (start_ok),
        .we_i   (byte_fire),
        .idx_i  (byte_idx_q),
        .byte_i (bus.byte_data_i),
        .word_o (packed_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_idx_q   <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= BASE_ADDR;
            cpu_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every decision below sees pre-edge state.
            mem_we_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE, ERR: begin
                    if (bus.start_i) begin
                        cpu_rst_q <= 1'b1;
                        done_q    <= 1'b0;
                        if (start_ok) begin
                            state_q      <= RECV;
                            len_q        <= bus.len_i;
                            word_cnt_q   <= '0;
                            byte_idx_q   <= '0;
                            byte_ready_q <= 1'b1;
                            err_q        <= 1'b0;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (byte_fire) begin
                        byte_idx_q <= byte_idx_q + 1'b1;
                        if (byte_idx_q == LAST_IDX) begin
                            state_q      <= WRITE;
                            byte_ready_q <= 1'b0;
                            mem_we_q     <= 1'b1;
                            mem_addr_q   <= mem_addr_d;
                        end
                    end
                end
                WRITE: begin
                    if (word_cnt_q + 16'd1 == len_q) begin
                        state_q   <= DONE;
                        cpu_rst_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        state_q      <= RECV;
                        word_cnt_q   <= word_cnt_q + 16'd1;
                        byte_idx_q   <= '0;
                        byte_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.byte_ready_o = byte_ready_q;
    assign bus.mem_we_o     = mem_we_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_wdata_o  = DATA_WIDTH'(packed_word);
    assign bus.cpu_rst_o    = cpu_rst_q;
    assign bus.done_o       = done_q;
    assign bus.err_o        = err_q;

endmodule
